// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: writeback request/grant bus plus register-file write port.
// Forwarding signals are present only when WB_ARBITER_FWD_EN is defined.
interface wb_arbiter_if #(
    parameter int N_REQ      = 3,
    parameter int reg_width  = 32,
    parameter int addr_width = 5
);
    logic                                iHold;
    logic [N_REQ-1:0]                    iValid;
    logic [N_REQ-1:0][addr_width-1:0]    iAddr;
    logic [N_REQ-1:0][reg_width-1:0]     iValue;
    logic [N_REQ-1:0]                    oReady;
    logic                                oWriteEn;
    logic [addr_width-1:0]               oRdAddr;
    logic [reg_width-1:0]                oRdValue;
`ifdef WB_ARBITER_FWD_EN
    logic [addr_width-1:0]               iAddrRs1;
    logic [addr_width-1:0]               iAddrRs2;
    logic                                oFwdRs1Hit;
    logic                                oFwdRs2Hit;
    logic [reg_width-1:0]                oFwdRs1;
    logic [reg_width-1:0]                oFwdRs2;
    modport master (
        output iHold, iValid, iAddr, iValue, iAddrRs1, iAddrRs2,
        input  oReady, oWriteEn, oRdAddr, oRdValue, oFwdRs1Hit, oFwdRs2Hit, oFwdRs1, oFwdRs2
    );
    modport slave (
        input  iHold, iValid, iAddr, iValue, iAddrRs1, iAddrRs2,
        output oReady, oWriteEn, oRdAddr, oRdValue, oFwdRs1Hit, oFwdRs2Hit, oFwdRs1, oFwdRs2
    );
`else
    modport master (
        output iHold, iValid, iAddr, iValue,
        input  oReady, oWriteEn, oRdAddr, oRdValue
    );
    modport slave (
        input  iHold, iValid, iAddr, iValue,
        output oReady, oWriteEn, oRdAddr, oRdValue
    );
`endif
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter with a one-cycle registered register-file write port.
// Define WB_ARBITER_FWD_EN to add rs1/rs2 forwarding from the pending write.
module wb_arbiter #(
    parameter int N_REQ      = 3,
    parameter int reg_width  = 32,
    parameter int addr_width = 5
) (
    input logic         iClk,
    input logic         nRst,
    wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0]         ptr;
    logic [PW-1:0]         gnt_idx;
    logic [PW-1:0]         idx;
    logic                  found;
    logic                  gnt;
    logic                  write_en;
    logic [addr_width-1:0] rd_addr;
    logic [reg_width-1:0]  rd_value;

    // Search upward from ptr with wrap; first valid requester wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (!found && bus.iValid[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt = found && !bus.iHold && nRst;
    end

    assign bus.oReady = gnt ? {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx : '0;

    // Grants to x0 still complete the handshake but never reach the register file.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            ptr      <= '0;
            write_en <= 1'b0;
            rd_addr  <= '0;
            rd_value <= '0;
        end else if (gnt) begin
            ptr      <= (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            write_en <= bus.iAddr[gnt_idx] != '0;
            rd_addr  <= bus.iAddr[gnt_idx];
            rd_value <= bus.iValue[gnt_idx];
        end else begin
            write_en <= 1'b0;
        end
    end

    assign bus.oWriteEn = write_en;
    assign bus.oRdAddr  = rd_addr;
    assign bus.oRdValue = rd_value;

`ifdef WB_ARBITER_FWD_EN
    assign bus.oFwdRs1Hit = write_en && rd_addr != '0 && bus.iAddrRs1 == rd_addr;
    assign bus.oFwdRs2Hit = write_en && rd_addr != '0 && bus.iAddrRs2 == rd_addr;
    assign bus.oFwdRs1    = bus.oFwdRs1Hit ? rd_value : '0;
    assign bus.oFwdRs2    = bus.oFwdRs2Hit ? rd_value : '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus for wb_arbiter; expected writes go into a queue
// that a monitor drains and compares cycle by cycle.
module tb_wb_arbiter;
    localparam int N = 3, RW = 32, AW = 5;

    logic iClk = 1'b0;
    logic nRst = 1'b1;
    wb_arbiter_if #(.N_REQ(N), .reg_width(RW), .addr_width(AW)) bus();
    wb_arbiter #(.N_REQ(N), .reg_width(RW), .addr_width(AW)) dut (.iClk(iClk), .nRst(nRst), .bus(bus));

    always #5 iClk = ~iClk;

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [RW-1:0] v;
    } wr_t;

    wr_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one cycle of requests, check the grant, queue the write it should produce.
    task automatic issue(input logic [N-1:0] v, input logic h, input logic [N-1:0] exp_rdy, input string name);
        wr_t e;
        bus.iValid = v;
        bus.iHold  = h;
        #1;
        chk(name, bus.oReady, exp_rdy);
        for (int i = 0; i < N; i++)
            if (exp_rdy[i] && bus.iAddr[i] != '0) begin
                e.c = cyc + 1;
                e.a = bus.iAddr[i];
                e.v = bus.iValue[i];
                exp_q.push_back(e);
            end
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        bus.iValid = '1;
        bus.iHold  = 1'b0;
        #2;
        nRst = 1'b0;
        #1;
        chk("rst_write_en", bus.oWriteEn, 0);
        chk("rst_rd_addr", bus.oRdAddr, 0);
        chk("rst_rd_value", bus.oRdValue, 0);
        chk("rst_ready", bus.oReady, 0);
        exp_q.delete();
        @(negedge iClk);
        nRst = 1'b1;
        bus.iValid = '0;
    endtask

    always @(posedge iClk) begin
        wr_t  e;
        logic exp_we;
        #2;
        if (mon_en) begin
            exp_we = exp_q.size() > 0 && exp_q[0].c <= cyc;
            chk("mon_write_en", bus.oWriteEn, exp_we);
            if (exp_we) begin
                e = exp_q.pop_front();
                chk("mon_rd_addr", bus.oRdAddr, e.a);
                chk("mon_rd_value", bus.oRdValue, e.v);
            end
        end
    end

    initial begin
        bus.iHold  = 1'b0;
        bus.iValid = '0;
        bus.iAddr[0] = 5'd1;  bus.iValue[0] = 32'h1111_0000;
        bus.iAddr[1] = 5'd2;  bus.iValue[1] = 32'h2222_0000;
        bus.iAddr[2] = 5'd3;  bus.iValue[2] = 32'h3333_0000;
`ifdef WB_ARBITER_FWD_EN
        bus.iAddrRs1 = '0;
        bus.iAddrRs2 = '0;
`endif
        do_reset();
        mon_en = 1'b1;

        bus.iAddr[1] = 5'd5; bus.iValue[1] = 32'hDEAD_BEEF;
        issue(3'b010, 0, 3'b010, "single_req1");
        issue(3'b000, 0, 3'b000, "idle");
        bus.iAddr[1] = 5'd2; bus.iValue[1] = 32'h2222_0000;

        do_reset();
        issue(3'b111, 0, 3'b001, "rr_0");
        issue(3'b111, 0, 3'b010, "rr_1");
        issue(3'b111, 0, 3'b100, "rr_2");
        issue(3'b111, 0, 3'b001, "rr_3");
        issue(3'b111, 0, 3'b010, "rr_4");
        issue(3'b111, 0, 3'b100, "rr_5");

        bus.iAddr[0] = 5'd0; bus.iValue[0] = 32'h0000_1234;
        issue(3'b001, 0, 3'b001, "x0_grant");
        bus.iAddr[0] = 5'd1; bus.iValue[0] = 32'h1111_0000;

        issue(3'b100, 0, 3'b100, "pre_hold_gnt2");
        issue(3'b011, 1, 3'b000, "hold_0");
        issue(3'b011, 1, 3'b000, "hold_1");
        issue(3'b011, 1, 3'b000, "hold_2");
        issue(3'b011, 0, 3'b001, "hold_release");
        issue(3'b011, 0, 3'b010, "after_release");

        issue(3'b101, 0, 3'b100, "skip_1");
        issue(3'b101, 0, 3'b001, "wrap_0");
        issue(3'b101, 0, 3'b100, "skip_again");

        issue(3'b100, 0, 3'b100, "gnt2_before_rst");
        do_reset();
        issue(3'b111, 0, 3'b001, "post_rst_gnt0");

`ifdef WB_ARBITER_FWD_EN
        bus.iAddr[0] = 5'd7; bus.iValue[0] = 32'hA5A5_A5A5;
        bus.iAddrRs1 = 5'd7;
        bus.iAddrRs2 = 5'd0;
        issue(3'b001, 0, 3'b001, "fwd_gnt");
        bus.iValid = '0;
        #1;
        chk("fwd_rs1_hit", bus.oFwdRs1Hit, 1);
        chk("fwd_rs1", bus.oFwdRs1, 32'hA5A5_A5A5);
        chk("fwd_rs2_hit", bus.oFwdRs2Hit, 0);
        chk("fwd_rs2", bus.oFwdRs2, 0);
`endif
        issue(3'b000, 0, 3'b000, "idle_end0");
        issue(3'b000, 0, 3'b000, "idle_end1");
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of writeback requesters (2..8).
REQ-002 SHALL have parameter reg_width, default RegWidth (32), register value width.
REQ-003 SHALL have parameter addr_width, default RegAddrWidth (5), register address width.
REQ-004 SHALL have port iClk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port nRst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port iHold  input  1  pipeline freeze; no grants while high.
REQ-007 SHALL have port iValid  input  N_REQ  per-requester writeback request.
REQ-008 SHALL have port iAddr  input  N_REQ x addr_width  per-requester destination register.
REQ-009 SHALL have port iValue  input  N_REQ x reg_width  per-requester write data.
REQ-010 SHALL have port oReady  output  N_REQ  one-hot grant; transfer when iValid[i] & oReady[i].
REQ-011 SHALL have port oWriteEn  output  1  register file write enable.
REQ-012 SHALL have port oRdAddr  output  addr_width  register file write address.
REQ-013 SHALL have port oRdValue  output  reg_width  register file write data.

Function
REQ-014 SHALL assert at most one oReady bit per cycle; oReady combinational from iValid, iHold and the priority pointer.
REQ-015 SHALL drive oReady all-zero whenever iHold=1 or iValid=0.
REQ-016 SHALL pick the first valid requester at or after pointer ptr, searching upward with wrap from N_REQ-1 to 0.
REQ-017 SHALL, on a grant to index g, update ptr to g+1, wrapping N_REQ-1 -> 0; ptr unchanged in cycles without a grant.
REQ-018 SHALL register the granted request: next cycle oWriteEn=1, oRdAddr=iAddr[g], oRdValue=iValue[g]; latency exactly 1 cycle.
REQ-019 SHALL complete the handshake for a request with iAddr[g]=0 but drive oWriteEn=0 the following cycle (x0 writes dropped).
REQ-020 SHALL drive oWriteEn=0 in any cycle following a no-grant cycle; oRdAddr/oRdValue hold their last values.
REQ-021 SHALL sustain one write per cycle with continuous requests (no bubbles).
REQ-022 SHALL guarantee a continuously valid requester is granted within N_REQ cycles of non-hold operation.
REQ-023 SHALL treat iValid deassertion before grant as request withdrawal; no state is kept for ungranted requests.
REQ-024 SHALL, when iHold rises, still complete the write already registered (oWriteEn honoured in that cycle).

Reset
REQ-025 SHALL, on nRst low, immediately clear oWriteEn=0, oRdAddr=0, oRdValue=0, ptr=0, independent of iClk.
REQ-026 SHALL, while nRst low, drive oReady all-zero; a registered write pending at reset assertion is discarded.
REQ-027 SHALL resume arbitration on the first rising edge after nRst deasserts, starting from requester 0.

Configuration
REQ-028 SHALL implement writeback forwarding only when macro WB_ARBITER_FWD_EN is defined.
REQ-029 SHALL, with WB_ARBITER_FWD_EN, add inputs iAddrRs1/iAddrRs2 (addr_width) and outputs oFwdRs1Hit/oFwdRs2Hit (1), oFwdRs1/oFwdRs2 (reg_width).
REQ-030 SHALL, with WB_ARBITER_FWD_EN, assert oFwdRsNHit combinationally when oWriteEn=1 and iAddrRsN=oRdAddr (nonzero), driving oFwdRsN=oRdValue; else hit=0, data=0.
REQ-031 SHALL, without WB_ARBITER_FWD_EN, omit the forwarding ports and logic entirely; all other behaviour identical.

Verification
REQ-032 SHALL cover: only iValid[1]=1, iAddr[1]=5, iValue[1]=0xDEADBEEF -> oReady=3'b010; next cycle oWriteEn=1, oRdAddr=5, oRdValue=0xDEADBEEF.
REQ-033 SHALL cover: iValid=3'b111 held 6 cycles from reset -> grants 0,1,2,0,1,2; oWriteEn=1 on cycles 2..7.
REQ-034 SHALL cover: iValid[0]=1, iAddr[0]=0, iValue[0]=0x1234 -> oReady[0]=1; next cycle oWriteEn=0.
REQ-035 SHALL cover: iValid=3'b011 with iHold=1 for 3 cycles -> oReady=0 throughout, oWriteEn=0 after the first hold cycle; on release grant requester 0.
REQ-036 SHALL cover: nRst pulsed low mid-cycle after grant to requester 2 -> oWriteEn=0 immediately, next grant after release goes to requester 0.
REQ-037 SHALL cover (WB_ARBITER_FWD_EN): pending write x7=0xA5A5A5A5, iAddrRs1=7, iAddrRs2=0 -> oFwdRs1Hit=1, oFwdRs1=0xA5A5A5A5, oFwdRs2Hit=0.
